// File: rtl/iccm_loader.sv
// iccm_loader: boot-time ICCM image loader.
//   Assembles a little-endian byte stream into 32-bit words and issues one
//   controller write per word into ICCM at base_addr + word index (the address
//   wraps modulo 2^ADDR_WIDTH). The core is held in reset (core_hold) until a
//   load completes.
//   Optional build macro ICCM_LOADER_CHECKSUM_EN: after the last data word,
//   four more bytes are taken as the expected mod-2^32 sum of all data words.
//   A mismatch sets the sticky err flag and keeps core_hold asserted. The
//   checksum word is never written to ICCM.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, abort            begin a load (ignored unless idle) / cancel a load
//   base_addr, word_count   load geometry, sampled on start
//   s_valid, s_data, s_ready  byte stream handshake
//   cntlr_wr, cntlr_waddr, cntlr_wr_data  ICCM controller write port
//   busy, done, core_hold, err            status
module iccm_loader #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  output logic                  s_ready,
  output logic                  cntlr_wr,
  output logic [ADDR_WIDTH-1:0] cntlr_waddr,
  output logic [DATA_WIDTH-1:0] cntlr_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  core_hold,
  output logic                  err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ASSEMBLE = 3'd1;
  localparam logic [2:0] S_WRITE    = 3'd2;
  localparam logic [2:0] S_DONE     = 3'd4;
`ifdef ICCM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK    = 3'd3;
`endif

  localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH:0]   remain_q, remain_d;   // data words still to write
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;         // word index within the image
  logic [1:0]            byte_q, byte_d;       // next byte lane to fill
  logic [DATA_WIDTH-9:0] part_q, part_d;       // lower three lanes of the word
  logic                  s_ready_q, s_ready_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  hold_q, hold_d;
`ifdef ICCM_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic                  err_q, err_d;
`endif

  logic                  hs;
  logic [DATA_WIDTH-1:0] word;

  assign hs   = s_valid & s_ready_q;
  // Fourth byte goes straight to the top lane; the word is complete this cycle.
  assign word = {s_data, part_q};

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    remain_d  = remain_q;
    idx_d     = idx_q;
    byte_d    = byte_q;
    part_d    = part_q;
    s_ready_d = s_ready_q;
    wr_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hold_d    = hold_q;
`ifdef ICCM_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
    err_d     = err_q;
`endif

    // Lanes 0..2 fill the same way in ASSEMBLE and CHECK.
    if (hs) begin
      case (byte_q)
        2'd0:    part_d[7:0]   = s_data;
        2'd1:    part_d[15:8]  = s_data;
        2'd2:    part_d[23:16] = s_data;
        default: part_d        = part_q;
      endcase
    end

    if (abort) begin
      // Partial word dropped; core_hold deliberately left as it is.
      state_d   = S_IDLE;
      s_ready_d = 1'b0;
      busy_d    = 1'b0;
      part_d    = part_q;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            base_d   = base_addr;
            remain_d = word_count;
            idx_d    = '0;
            byte_d   = '0;
`ifdef ICCM_LOADER_CHECKSUM_EN
            sum_d    = '0;
            err_d    = 1'b0;
`endif
            if (word_count != '0) begin
              state_d   = S_ASSEMBLE;
              s_ready_d = 1'b1;
              busy_d    = 1'b1;
              hold_d    = 1'b1;
            end else begin
              state_d = S_DONE;
              done_d  = 1'b1;
              hold_d  = 1'b0;
            end
          end
        end
        S_ASSEMBLE: begin
          if (hs) begin
            if (byte_q == 2'd3) begin
              s_ready_d = 1'b0;
              wr_d      = 1'b1;
              waddr_d   = base_q + idx_q;
              wdata_d   = word;
              byte_d    = '0;
              state_d   = S_WRITE;
`ifdef ICCM_LOADER_CHECKSUM_EN
              sum_d     = sum_q + word;
`endif
            end else begin
              byte_d = byte_q + 2'd1;
            end
          end
        end
        S_WRITE: begin
          idx_d    = idx_q + 1'b1;
          remain_d = remain_q - 1'b1;
          if (remain_q == CNT_ONE) begin
`ifdef ICCM_LOADER_CHECKSUM_EN
            state_d   = S_CHECK;
            s_ready_d = 1'b1;
`else
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            hold_d  = 1'b0;
`endif
          end else begin
            state_d   = S_ASSEMBLE;
            s_ready_d = 1'b1;
          end
        end
`ifdef ICCM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (hs) begin
            if (byte_q == 2'd3) begin
              s_ready_d = 1'b0;
              byte_d    = '0;
              state_d   = S_DONE;
              done_d    = 1'b1;
              busy_d    = 1'b0;
              // err was cleared on start, so a mismatch here is the only source.
              err_d     = (word != sum_q);
              hold_d    = (word != sum_q);
            end else begin
              byte_d = byte_q + 2'd1;
            end
          end
        end
`endif
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      remain_q  <= '0;
      idx_q     <= '0;
      byte_q    <= '0;
      part_q    <= '0;
      s_ready_q <= 1'b0;
      wr_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hold_q    <= 1'b1;
`ifdef ICCM_LOADER_CHECKSUM_EN
      sum_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      remain_q  <= remain_d;
      idx_q     <= idx_d;
      byte_q    <= byte_d;
      part_q    <= part_d;
      s_ready_q <= s_ready_d;
      wr_q      <= wr_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hold_q    <= hold_d;
`ifdef ICCM_LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
      err_q     <= err_d;
`endif
    end
  end

  assign s_ready       = s_ready_q;
  assign cntlr_wr      = wr_q;
  assign cntlr_waddr   = waddr_q;
  assign cntlr_wr_data = wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign core_hold     = hold_q;
`ifdef ICCM_LOADER_CHECKSUM_EN
  assign err           = err_q;
`else
  assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_iccm_loader.sv
// Directed testbench for iccm_loader: reset state, single/multi-word loads,
// address wrap, gapped stream, abort, zero-count, ignored start, reset
// mid-load and (when built with ICCM_LOADER_CHECKSUM_EN) checksum pass/fail.
module tb_iccm_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [10:0] base_addr = '0;
  logic [11:0] word_count = '0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready, cntlr_wr, busy, done, core_hold, err;
  logic [10:0] cntlr_waddr;
  logic [31:0] cntlr_wr_data;

  iccm_loader #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .word_count(word_count),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .cntlr_wr(cntlr_wr), .cntlr_waddr(cntlr_waddr), .cntlr_wr_data(cntlr_wr_data),
    .busy(busy), .done(done), .core_hold(core_hold), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  logic [10:0] wa_q[$];
  logic [31:0] wd_q[$];

  // Log every write and done pulse (pre-edge values at each rising edge).
  always @(posedge clk) begin
    if (cntlr_wr) begin
      wa_q.push_back(cntlr_waddr);
      wd_q.push_back(cntlr_wr_data);
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
  endtask

  task automatic do_start(input logic [10:0] b, input logic [11:0] c);
    base_addr = b; word_count = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present a byte and hold it until accepted; returns at edge+1.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    s_valid = 1'b1; s_data = b;
    @(negedge clk);
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("s_ready_timeout", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) begin
      if (gap) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      send_byte(w[i*8 +: 8]);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_cntlr_wr", 32'(cntlr_wr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_core_hold", 32'(core_hold), 1);
    check("rst_err", 32'(err), 0);
    check("rst_waddr", 32'(cntlr_waddr), 0);
    check("rst_wdata", cntlr_wr_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1 single word
    clear_log();
    do_start(11'd0, 12'd1);
    check("t1_busy", 32'(busy), 1);
    check("t1_s_ready", 32'(s_ready), 1);
    check("t1_hold", 32'(core_hold), 1);
    send_word(32'h12345678, 1'b0);
    check("t1_wr", 32'(cntlr_wr), 1);
    check("t1_addr", 32'(cntlr_waddr), 0);
    check("t1_data", cntlr_wr_data, 32'h12345678);
    check("t1_s_ready_low", 32'(s_ready), 0);
    @(posedge clk); #1;
    check("t1_done", 32'(done), 1);
    check("t1_busy_off", 32'(busy), 0);
    check("t1_hold_off", 32'(core_hold), 0);
    check("t1_wr_off", 32'(cntlr_wr), 0);
    @(posedge clk); #1;
    check("t1_done_1cyc", 32'(done), 0);
    check("t1_hold_stays", 32'(core_hold), 0);
    check("t1_nwr", wa_q.size(), 1);
    check("t1_ndone", done_cnt, 1);
    check("t1_err", 32'(err), 0);

    // T2 address wrap
    clear_log();
    do_start(11'd2046, 12'd3);
    for (int k = 0; k < 3; k++) send_word(32'hA0B0C0D0 + k, 1'b0);
    wait_done();
    @(posedge clk); #1;
    check("t2_nwr", wa_q.size(), 3);
    check("t2_addr0", 32'(wa_q[0]), 2046);
    check("t2_addr1", 32'(wa_q[1]), 2047);
    check("t2_addr2", 32'(wa_q[2]), 0);
    check("t2_data0", wd_q[0], 32'hA0B0C0D0);
    check("t2_data2", wd_q[2], 32'hA0B0C0D2);
    check("t2_ndone", done_cnt, 1);

    // T3 gapped stream
    clear_log();
    do_start(11'd5, 12'd2);
    send_word(32'h11223344, 1'b1);
    send_word(32'h55667788, 1'b1);
    wait_done();
    @(posedge clk); #1;
    check("t3_nwr", wa_q.size(), 2);
    check("t3_addr0", 32'(wa_q[0]), 5);
    check("t3_addr1", 32'(wa_q[1]), 6);
    check("t3_data0", wd_q[0], 32'h11223344);
    check("t3_data1", wd_q[1], 32'h55667788);

    // T4 abort mid-word, then a clean reload
    clear_log();
    do_start(11'd10, 12'd2);
    send_byte(8'hAA);
    send_byte(8'hBB);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("t4_busy", 32'(busy), 0);
    check("t4_hold", 32'(core_hold), 1);
    check("t4_s_ready", 32'(s_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    check("t4_nwr", wa_q.size(), 0);
    check("t4_ndone", done_cnt, 0);
    clear_log();
    do_start(11'd20, 12'd1);
    send_word(32'hDEADBEEF, 1'b0);
    wait_done();
    @(posedge clk); #1;
    check("t4_re_nwr", wa_q.size(), 1);
    check("t4_re_addr", 32'(wa_q[0]), 20);
    check("t4_re_data", wd_q[0], 32'hDEADBEEF);
    check("t4_re_hold", 32'(core_hold), 0);

    // T5 zero count, then start while busy
    clear_log();
    do_start(11'd7, 12'd0);
    check("t5_done", 32'(done), 1);
    check("t5_busy", 32'(busy), 0);
    @(posedge clk); #1;
    check("t5_done_off", 32'(done), 0);
    check("t5_nwr", wa_q.size(), 0);
    clear_log();
    do_start(11'd100, 12'd1);
    send_byte(8'h01);
    do_start(11'd200, 12'd5);
    check("t5_busy_still", 32'(busy), 1);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    check("t5_addr", 32'(cntlr_waddr), 100);
    check("t5_data", cntlr_wr_data, 32'h04030201);
    wait_done();
    @(posedge clk); #1;
    check("t5_nwr2", wa_q.size(), 1);
    check("t5_ndone", done_cnt, 1);
    check("t5_idle", 32'(busy), 0);

`ifdef ICCM_LOADER_CHECKSUM_EN
    // T6 checksum pass and fail
    clear_log();
    do_start(11'd0, 12'd2);
    send_word(32'd1, 1'b0);
    send_word(32'd2, 1'b0);
    send_word(32'd3, 1'b0);
    wait_done();
    check("t6_ok_err", 32'(err), 0);
    check("t6_ok_hold", 32'(core_hold), 0);
    @(posedge clk); #1;
    check("t6_ok_nwr", wa_q.size(), 2);
    clear_log();
    do_start(11'd0, 12'd2);
    send_word(32'd1, 1'b0);
    send_word(32'd2, 1'b0);
    send_word(32'd4, 1'b0);
    wait_done();
    check("t6_bad_err", 32'(err), 1);
    check("t6_bad_hold", 32'(core_hold), 1);
    @(posedge clk); #1;
    check("t6_bad_nwr", wa_q.size(), 2);
    check("t6_bad_ndone", done_cnt, 1);
    check("t6_err_sticky", 32'(err), 1);
`endif

    // Reset in the middle of a word
    clear_log();
    do_start(11'd30, 12'd1);
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h30);
    rst_n = 1'b0;
    #1;
    check("rstmid_hold", 32'(core_hold), 1);
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_s_ready", 32'(s_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rstmid_nwr", wa_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
